booth_divider: RTL and testbench
================================

# booth_divider

Iterative 32-bit integer divider: the inverse datapath of the radix-16 Booth multiplier, producing quotient and remainder for signed (two's complement) or unsigned operands. One quotient bit per cycle (radix-2 restoring shift-subtract on magnitudes), with a start/done handshake. Sits beside the multiplier in the arithmetic unit and shares its operand width parameter.

## Interface
- LENGTH, 32, operand/quotient/remainder width (even, ≥4)
- sys_clk  in  1  clock, rising-edge
- sys_rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only while idle
- sign  in  1  1 = signed two's complement, 0 = unsigned; captured with start
- A  in  LENGTH  dividend; captured with start
- B  in  LENGTH  divisor; captured with start
- busy  out  1  high while a division is in progress
- done  out  1  one-cycle pulse, Q/R/div_zero valid
- Q  out  LENGTH  quotient, held until next done
- R  out  LENGTH  remainder, held until next done
- div_zero  out  1  B was 0 for the completed division, held with Q/R

## Operation
- States: IDLE, CALC, FIX.
- IDLE: if start=1 at an edge, capture sign, A and B. Store |A|, |B| when sign=1, else the raw values. Record neg_q = sign & (A[MSB]^B[MSB]), neg_r = sign & A[MSB], and zero = (B==0). Clear the partial remainder (LENGTH+1 bits) and the iteration counter. Go to CALC.
- CALC, each cycle:
  - Shift {rem, dividend} left by 1.
  - Trial = rem − divisor, in LENGTH+1 bits.
  - If trial ≥ 0: rem = trial, quotient bit = 1. Else keep rem, quotient bit = 0.
  - After LENGTH iterations go to FIX.
- FIX (1 cycle):
  - Q = neg_q ? −mag_q : mag_q.
  - R = neg_r ? −mag_r : mag_r.
  - div_zero = zero.
  - done = 1 for this cycle. Return to IDLE.
- Divide by zero: Q = all ones, R = A as captured, div_zero = 1. Sign fix-up is suppressed. Latency is identical to a normal division.
- Signed overflow (A = −2^(LENGTH−1), B = −1): Q = 0x80000000, R = 0. This falls out of the magnitude path with no special case.
- Remainder sign follows the dividend. Quotient truncates toward zero.
- start while busy: ignored; the captured operands are not disturbed.

## Timing
- Reset values: busy=0, done=0, Q=0, R=0, div_zero=0, state IDLE.
- start accepted at edge t0:
  - busy=1 from t0 through t0+LENGTH+1.
  - At edge t0+LENGTH+1: done=1, Q/R/div_zero updated, busy=0 (same edge).
  - Latency is LENGTH+1 = 33 cycles.
- done is high for exactly one cycle.
- start=1 in the cycle done is high is accepted, since the state is IDLE. This gives back-to-back throughput of one result per 34 cycles.
- Reset asserted mid-division aborts immediately to reset values. No done pulse is issued for the aborted operation.
- Outputs are registered only; no combinational path from inputs to outputs.

## Test plan
- Unsigned: A=100, B=7, sign=0 → after 33 cycles done=1, Q=14, R=2, div_zero=0; busy high for exactly 33 cycles.
- Signed mixed signs: A=−7 (0xFFFFFFF9), B=2, sign=1 → Q=0xFFFFFFFD (−3), R=0xFFFFFFFF (−1). A=7, B=−2 → Q=−3, R=1.
- Divide by zero: A=0x12345678, B=0, sign=0 and sign=1 → Q=0xFFFFFFFF, R=0x12345678, div_zero=1, done at cycle 33.
- Overflow and extremes:
  - A=0x80000000, B=0xFFFFFFFF, sign=1 → Q=0x80000000, R=0.
  - Same operands with sign=0 → Q=0, R=0x80000000.
  - A=0xFFFFFFFF, B=1, sign=0 → Q=0xFFFFFFFF, R=0.
- Handshake:
  - Second start with different operands at cycle 10 of a division → ignored; first result unchanged.
  - start held high during done → next result lands exactly 34 cycles after the first done.
- Reset mid-op: assert sys_rst asynchronously at cycle 15 → busy, done, Q, R and div_zero return to 0 immediately; no done pulse follows. A new start after release completes normally.

Source files
------------

// File: rtl/booth_divider_if.sv
// Handshake and operand/result bundle for booth_divider.
// start/done protocol: start is sampled only while the divider is idle
// (busy=0); an accepted start raises busy on the same edge, and done pulses
// for exactly one cycle when Q/R/div_zero update. A start seen while busy is
// ignored. dbg_state mirrors the internal FSM state for observation.
interface booth_divider_if #(
  parameter int LENGTH = 32
);
  logic              start;
  logic              sign;
  logic [LENGTH-1:0] A;
  logic [LENGTH-1:0] B;
  logic              busy;
  logic              done;
  logic [LENGTH-1:0] Q;
  logic [LENGTH-1:0] R;
  logic              div_zero;
  logic [1:0]        dbg_state;

  modport master (
    output start, sign, A, B,
    input  busy, done, Q, R, div_zero, dbg_state
  );

  modport slave (
    input  start, sign, A, B,
    output busy, done, Q, R, div_zero, dbg_state
  );
endinterface

// File: rtl/booth_divider.sv
// Iterative signed/unsigned divider: radix-2 restoring shift-subtract on
// operand magnitudes, one quotient bit per cycle, sign fix-up in a final
// cycle. Latency from accepted start to done is LENGTH+1 cycles.
module booth_divider #(
  parameter int LENGTH = 32
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  booth_divider_if.slave    bus
);

  localparam int CW = $clog2(LENGTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam logic [CW-1:0] LAST_ITER = CW'(LENGTH - 1);

  logic [1:0]        state_q,  state_d;
  logic [CW-1:0]     cnt_q,    cnt_d;
  // Dividend magnitude; quotient bits shift in at the bottom as it drains.
  logic [LENGTH-1:0] dvd_q,    dvd_d;
  logic [LENGTH-1:0] dvs_q,    dvs_d;
  // Partial remainder is always below the divisor, so LENGTH bits hold it;
  // the extra bit only exists in the shifted/trial values below.
  logic [LENGTH-1:0] rem_q,    rem_d;
  logic              neg_q_q,  neg_q_d;
  logic              neg_r_q,  neg_r_d;
  logic              zero_q,   zero_d;
  logic              busy_q,   busy_d;
  logic              done_q,   done_d;
  logic [LENGTH-1:0] quo_q,    quo_d;
  logic [LENGTH-1:0] rmd_q,    rmd_d;
  logic              dz_q,     dz_d;

  logic [LENGTH:0]   shifted;
  logic [LENGTH:0]   trial;
  logic              qbit;

  // Next-state, datapath step and result fix-up.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    zero_d  = zero_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    dz_d    = dz_q;

    shifted = {rem_q, dvd_q[LENGTH-1]};
    trial   = shifted - {1'b0, dvs_q};
    qbit    = ~trial[LENGTH];

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_CALC;
          busy_d  = 1'b1;
          dvd_d   = (bus.sign && bus.A[LENGTH-1]) ? -bus.A : bus.A;
          dvs_d   = (bus.sign && bus.B[LENGTH-1]) ? -bus.B : bus.B;
          neg_q_d = bus.sign & (bus.A[LENGTH-1] ^ bus.B[LENGTH-1]);
          neg_r_d = bus.sign & bus.A[LENGTH-1];
          zero_d  = (bus.B == '0);
          rem_d   = '0;
          cnt_d   = '0;
        end
      end
      S_CALC: begin
        rem_d = qbit ? trial[LENGTH-1:0] : shifted[LENGTH-1:0];
        dvd_d = {dvd_q[LENGTH-2:0], qbit};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        // With a zero divisor every trial succeeds, so the remainder ends up
        // holding |A|; re-applying the dividend sign restores A exactly.
        // Only the quotient needs forcing to all ones.
        quo_d   = zero_q ? '1 : (neg_q_q ? -dvd_q : dvd_q);
        rmd_d   = neg_r_q ? -rem_q : rem_q;
        dz_d    = zero_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers, cleared by asynchronous reset.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quo_q   <= '0;
      rmd_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      dz_q    <= dz_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.Q         = quo_q;
  assign bus.R         = rmd_q;
  assign bus.div_zero  = dz_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_booth_divider.sv
// Directed scoreboard bench for booth_divider.
module tb_booth_divider;

  localparam int LENGTH = 32;
  localparam int W      = 2 * LENGTH + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  booth_divider_if #(.LENGTH(LENGTH)) bus ();

  booth_divider #(.LENGTH(LENGTH)) dut (
    .sys_clk (clk),
    .sys_rst (rst),
    .bus     (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           lat_q[$];
  int           errors = 0;
  int           checks = 0;
  int           busy_run = 0;
  logic [W-1:0] mon_e;
  int           mon_c;
  int           last_done_cyc = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops an expectation whenever the DUT signals done.
  always @(negedge clk) begin
    if (rst) begin
      busy_run = 0;
    end else begin
      if (bus.busy) busy_run++;
      if (bus.done) begin
        last_done_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 at cycle %0d expected no pending result", cyc);
        end else begin
          mon_e = exp_q.pop_front();
          mon_c = lat_q.pop_front();
          check("result{dz,Q,R}", {bus.div_zero, bus.Q, bus.R}, mon_e);
          check("done_cycle", W'(cyc), W'(mon_c));
          check("busy_cycles", W'(busy_run), W'(LENGTH + 1));
          check("busy_low_at_done", W'(bus.busy), '0);
        end
        busy_run = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (bus.busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) begin
      checks++;
      errors++;
      $display("FAIL wait_idle_timeout: busy=%0d expected 0 within 200 cycles", bus.busy);
    end
  endtask

  task automatic issue(input logic [LENGTH-1:0] a, input logic [LENGTH-1:0] b, input logic s,
                       input logic [LENGTH-1:0] eq, input logic [LENGTH-1:0] er, input logic ez,
                       input bit expect_result);
    wait_idle();
    bus.A     = a;
    bus.B     = b;
    bus.sign  = s;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    if (expect_result) begin
      exp_q.push_back({ez, eq, er});
      lat_q.push_back(cyc + LENGTH + 1);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: pending=%0d expected 0", exp_q.size());
      exp_q.delete();
      lat_q.delete();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.sign  = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_Q", W'(bus.Q), '0);
    check("reset_R", W'(bus.R), '0);
    check("reset_busy_done_dz", W'({bus.busy, bus.done, bus.div_zero}), '0);
    check("reset_state", W'(bus.dbg_state), '0);

    // Directed vectors: A, B, sign, expected Q, expected R, expected div_zero.
    issue(32'd100,       32'd7,        1'b0, 32'd14,        32'd2,        1'b0, 1);
    issue(32'hFFFFFFF9,  32'd2,        1'b1, 32'hFFFFFFFD,  32'hFFFFFFFF, 1'b0, 1);
    issue(32'd7,         32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD,  32'd1,        1'b0, 1);
    issue(32'hFFFFFFF9,  32'hFFFFFFFE, 1'b1, 32'd3,         32'hFFFFFFFF, 1'b0, 1);
    issue(32'h12345678,  32'd0,        1'b0, 32'hFFFFFFFF,  32'h12345678, 1'b1, 1);
    issue(32'h12345678,  32'd0,        1'b1, 32'hFFFFFFFF,  32'h12345678, 1'b1, 1);
    issue(32'hFFFFFFF9,  32'd0,        1'b1, 32'hFFFFFFFF,  32'hFFFFFFF9, 1'b1, 1);
    issue(32'h80000000,  32'hFFFFFFFF, 1'b1, 32'h80000000,  32'd0,        1'b0, 1);
    issue(32'h80000000,  32'hFFFFFFFF, 1'b0, 32'd0,         32'h80000000, 1'b0, 1);
    issue(32'hFFFFFFFF,  32'd1,        1'b0, 32'hFFFFFFFF,  32'd0,        1'b0, 1);
    issue(32'd5,         32'd9,        1'b0, 32'd0,         32'd5,        1'b0, 1);
    issue(32'd1000,      32'd10,       1'b1, 32'd100,       32'd0,        1'b0, 1);
    drain();

    // A second start at cycle 10 of a division is ignored.
    issue(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 1);
    repeat (9) @(negedge clk);
    bus.A     = 32'd50;
    bus.B     = 32'd3;
    bus.sign  = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    drain();
    check("ignored_start_no_extra_done", W'(bus.busy), '0);

    // start held high through done: second result lands 34 cycles later.
    issue(32'd200, 32'd9, 1'b0, 32'd22, 32'd2, 1'b0, 1);
    bus.A     = 32'hFFFFFF9C;
    bus.B     = 32'd7;
    bus.sign  = 1'b1;
    bus.start = 1'b1;
    begin
      int n = 0;
      while (!bus.done && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (!bus.done) begin
        checks++;
        errors++;
        $display("FAIL b2b_first_done_timeout: done=%0d expected 1", bus.done);
      end
    end
    @(negedge clk);
    bus.start = 1'b0;
    exp_q.push_back({1'b0, 32'hFFFFFFF2, 32'hFFFFFFFE});
    lat_q.push_back(last_done_cyc + LENGTH + 2);
    drain();

    // Asynchronous reset in the middle of a division.
    issue(32'h12345678, 32'd3, 1'b0, '0, '0, 1'b0, 0);
    repeat (14) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midreset_Q", W'(bus.Q), '0);
    check("midreset_R", W'(bus.R), '0);
    check("midreset_busy_done_dz", W'({bus.busy, bus.done, bus.div_zero}), '0);
    check("midreset_state", W'(bus.dbg_state), '0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    issue(32'd77, 32'd5, 1'b0, 32'd15, 32'd2, 1'b0, 1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global bound on simulation time.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, pending=%0d", exp_q.size());
    $fatal(1, "timeout");
  end

endmodule
